// File: rtl/chess_game_timer.sv
// N-player chess game clock: per-player seconds countdown with a shared
// prescaler, move handoff with optional Fischer increment, pause and flag fall.
module chess_game_timer #(
  parameter int CLOCK_FREQ   = 50000000,
  parameter int PLAYERS      = 2,
  parameter int TIME_WIDTH   = 12,
  parameter int INIT_SECONDS = 600,
  parameter int INCREMENT    = 0,
  localparam int PW = $clog2(PLAYERS)
) (
  input  logic                          clock,
  input  logic                          globalReset,
  input  logic                          StartStopSwitch,
  input  logic                          moveDone,
  input  logic                          newGame,
  output logic [PW-1:0]                 activePlayer,
  output logic [PLAYERS*TIME_WIDTH-1:0] timeLeft,
  output logic                          running,
  output logic                          timeout,
  output logic [PW-1:0]                 loser,
  output logic                          secondTick
);

  localparam int                    PSW    = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PSW-1:0]        PRE_TC = PSW'(CLOCK_FREQ - 1);
  localparam logic [TIME_WIDTH-1:0] T_INIT = TIME_WIDTH'(INIT_SECONDS);
  localparam int                    T_MAX  = (1 << TIME_WIDTH) - 1;
  localparam logic [PW-1:0]         LAST   = PW'(PLAYERS - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

  state_t                               state;
  logic                                 sw_p0, sw_p1, sw_s;
  logic [PSW-1:0]                       presc;
  logic [PLAYERS-1:0][TIME_WIDTH-1:0]   timers;
  logic [TIME_WIDTH-1:0]                cur, cur_dec;
  logic [PW-1:0]                        next_player;
  logic                                 tc, flag_fall;

  function automatic logic [TIME_WIDTH-1:0] sat_inc(input logic [TIME_WIDTH-1:0] t);
    int s;
    s = int'(t) + INCREMENT;
    return (s > T_MAX) ? TIME_WIDTH'(T_MAX) : TIME_WIDTH'(s);
  endfunction

  assign sw_s        = sw_p1;
  assign cur         = timers[activePlayer];
  assign cur_dec     = cur - 1'b1;
  assign tc          = (presc == PRE_TC);
  assign flag_fall   = tc && (cur == TIME_WIDTH'(1));
  assign next_player = (activePlayer == LAST) ? '0 : activePlayer + 1'b1;
  assign timeLeft    = timers;

  always_ff @(posedge clock or negedge globalReset) begin
    if (!globalReset) begin
      state        <= IDLE;
      sw_p0        <= 1'b0;
      sw_p1        <= 1'b0;
      presc        <= '0;
      timers       <= {PLAYERS{T_INIT}};
      activePlayer <= '0;
      running      <= 1'b0;
      timeout      <= 1'b0;
      loser        <= '0;
      secondTick   <= 1'b0;
    end else begin
      sw_p0      <= StartStopSwitch;
      sw_p1      <= sw_p0;
      secondTick <= 1'b0;
      if (newGame) begin
        state        <= IDLE;
        presc        <= '0;
        timers       <= {PLAYERS{T_INIT}};
        activePlayer <= '0;
        running      <= 1'b0;
        timeout      <= 1'b0;
        loser        <= '0;
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (sw_s) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            // A terminal count is settled before the move; a flag fall swallows the move.
            if (tc) begin
              presc      <= '0;
              secondTick <= 1'b1;
              if (flag_fall) begin
                timers[activePlayer] <= '0;
                state                <= OVER;
                running              <= 1'b0;
                timeout              <= 1'b1;
                loser                <= activePlayer;
              end else if (moveDone) begin
                timers[activePlayer] <= sat_inc(cur_dec);
                activePlayer         <= next_player;
              end else begin
                timers[activePlayer] <= cur_dec;
              end
            end else if (moveDone) begin
              timers[activePlayer] <= sat_inc(cur);
              activePlayer         <= next_player;
              presc                <= '0;
            end else begin
              presc <= presc + 1'b1;
            end
            if (!sw_s && !flag_fall) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chess_game_timer.sv
// Directed bench for chess_game_timer: per-cycle vector table on a 2-player
// instance plus short sequences for async reset, increment saturation and 3 players.
module tb_chess_game_timer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic globalReset;

  logic       sw_a = 1'b0, mv_a = 1'b0, ng_a = 1'b0;
  logic [0:0] ap_a, lo_a;
  logic [7:0] tl_a;
  logic       run_a, to_a, tk_a;

  logic       sw_b = 1'b0, mv_b = 1'b0, ng_b = 1'b0;
  logic [0:0] ap_b, lo_b;
  logic [5:0] tl_b;
  logic       run_b, to_b, tk_b;

  logic        sw_c = 1'b0, mv_c = 1'b0, ng_c = 1'b0;
  logic [1:0]  ap_c, lo_c;
  logic [11:0] tl_c;
  logic        run_c, to_c, tk_c;

  chess_game_timer #(.CLOCK_FREQ(4), .PLAYERS(2), .TIME_WIDTH(4), .INIT_SECONDS(3), .INCREMENT(0)) dut_a (
    .clock(clock), .globalReset(globalReset), .StartStopSwitch(sw_a), .moveDone(mv_a),
    .newGame(ng_a), .activePlayer(ap_a), .timeLeft(tl_a), .running(run_a),
    .timeout(to_a), .loser(lo_a), .secondTick(tk_a));

  chess_game_timer #(.CLOCK_FREQ(4), .PLAYERS(2), .TIME_WIDTH(3), .INIT_SECONDS(3), .INCREMENT(2)) dut_b (
    .clock(clock), .globalReset(globalReset), .StartStopSwitch(sw_b), .moveDone(mv_b),
    .newGame(ng_b), .activePlayer(ap_b), .timeLeft(tl_b), .running(run_b),
    .timeout(to_b), .loser(lo_b), .secondTick(tk_b));

  chess_game_timer #(.CLOCK_FREQ(4), .PLAYERS(3), .TIME_WIDTH(4), .INIT_SECONDS(3), .INCREMENT(0)) dut_c (
    .clock(clock), .globalReset(globalReset), .StartStopSwitch(sw_c), .moveDone(mv_c),
    .newGame(ng_c), .activePlayer(ap_c), .timeLeft(tl_c), .running(run_c),
    .timeout(to_c), .loser(lo_c), .secondTick(tk_c));

  typedef struct {
    int         rep;
    logic       sw, mv, ng;
    logic       run, ap;
    logic [3:0] t0, t1;
    logic       to, lo, tk;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic r(input int n, input bit sw, input bit mv, input bit ng,
                   input bit run, input bit ap, input int t0, input int t1,
                   input bit to, input bit lo, input bit tk);
    vec_t v;
    v.rep = n; v.sw = sw; v.mv = mv; v.ng = ng;
    v.run = run; v.ap = ap; v.t0 = 4'(t0); v.t1 = 4'(t1);
    v.to = to; v.lo = lo; v.tk = tk;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] pack_a();
    return 32'({run_a, ap_a, tl_a[3:0], tl_a[7:4], to_a, lo_a, tk_a});
  endfunction

  initial begin
    // sw mv ng | running ap t0 t1 timeout loser tick
    r(1, 1,1,0, 0,0,3,3,0,0,0);
    r(1, 1,0,0, 0,0,3,3,0,0,0);
    r(4, 1,0,0, 1,0,3,3,0,0,0);
    r(1, 1,0,0, 1,0,2,3,0,0,1);
    r(3, 1,0,0, 1,0,2,3,0,0,0);
    r(1, 1,0,0, 1,0,1,3,0,0,1);
    r(3, 1,0,0, 1,0,1,3,0,0,0);
    r(1, 1,0,0, 0,0,0,3,1,0,1);
    r(1, 1,1,0, 0,0,0,3,1,0,0);
    r(1, 1,0,0, 0,0,0,3,1,0,0);
    // collisions of moveDone with the terminal count
    r(1, 1,0,1, 0,0,3,3,0,0,0);
    r(4, 1,0,0, 1,0,3,3,0,0,0);
    r(1, 1,0,0, 1,0,2,3,0,0,1);
    r(3, 1,0,0, 1,0,2,3,0,0,0);
    r(1, 1,1,0, 1,1,1,3,0,0,1);
    r(3, 1,0,0, 1,1,1,3,0,0,0);
    r(1, 1,0,0, 1,1,1,2,0,0,1);
    r(1, 1,1,0, 1,0,1,2,0,0,0);
    r(3, 1,0,0, 1,0,1,2,0,0,0);
    r(1, 1,1,0, 0,0,0,2,1,0,1);
    // player 1 flags
    r(1, 1,0,1, 0,0,3,3,0,0,0);
    r(1, 1,0,0, 1,0,3,3,0,0,0);
    r(1, 1,1,0, 1,1,3,3,0,0,0);
    r(3, 1,0,0, 1,1,3,3,0,0,0);
    r(1, 1,0,0, 1,1,3,2,0,0,1);
    r(3, 1,0,0, 1,1,3,2,0,0,0);
    r(1, 1,0,0, 1,1,3,1,0,0,1);
    r(3, 1,0,0, 1,1,3,1,0,0,0);
    r(1, 1,0,0, 0,1,3,0,1,1,1);
    // pause with prescaler frozen at 2, then resume
    r(1, 1,0,1, 0,0,3,3,0,0,0);
    r(2, 0,0,0, 1,0,3,3,0,0,0);
    r(1, 0,0,0, 0,0,3,3,0,0,0);
    r(20,0,1,0, 0,0,3,3,0,0,0);
    r(2, 1,0,0, 0,0,3,3,0,0,0);
    r(2, 1,0,0, 1,0,3,3,0,0,0);
    r(1, 1,0,0, 1,0,2,3,0,0,1);

    globalReset = 1'b0;
    repeat (2) step();
    check("reset_a", pack_a(), 32'({1'b0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0}));
    check("reset_bc", 32'({tl_b, tl_c, run_b, run_c}), 32'({6'o33, 12'h333, 1'b0, 1'b0}));

    // asynchronous reset while running
    globalReset = 1'b1;
    sw_a = 1'b1;
    repeat (7) step();
    check("pre_rst_t0", 32'({run_a, tl_a[3:0]}), 32'({1'b1, 4'd2}));
    mv_a = 1'b1;
    step();
    mv_a = 1'b0;
    check("pre_rst_ap", 32'(ap_a), 32'd1);
    #2 globalReset = 1'b0;
    #1 check("async_rst", pack_a(), 32'({1'b0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0}));
    @(negedge clock);
    globalReset = 1'b1;
    sw_a = 1'b0;

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        sw_a = tbl[i].sw; mv_a = tbl[i].mv; ng_a = tbl[i].ng;
        step();
        check($sformatf("vec%0d.%0d", i, k), pack_a(),
              32'({tbl[i].run, tbl[i].ap, tbl[i].t0, tbl[i].t1, tbl[i].to, tbl[i].lo, tbl[i].tk}));
      end
    end
    sw_a = 1'b0; mv_a = 1'b0; ng_a = 1'b0;

    // increment and saturation at 7
    sw_b = 1'b1;
    repeat (3) step();
    check("b_running", 32'(run_b), 32'd1);
    repeat (4) step();
    check("b_t0_2", 32'(tl_b[2:0]), 32'd2);
    mv_b = 1'b1; step(); mv_b = 1'b0;
    check("b_mv1", 32'({ap_b, tl_b[2:0], tl_b[5:3]}), 32'({1'b1, 3'd4, 3'd3}));
    mv_b = 1'b1; step(); mv_b = 1'b0;
    check("b_mv2", 32'({ap_b, tl_b[2:0], tl_b[5:3]}), 32'({1'b0, 3'd4, 3'd5}));
    mv_b = 1'b1; step(); mv_b = 1'b0;
    check("b_mv3", 32'({ap_b, tl_b[2:0], tl_b[5:3]}), 32'({1'b1, 3'd6, 3'd5}));
    mv_b = 1'b1; step(); mv_b = 1'b0;
    check("b_mv4", 32'({ap_b, tl_b[2:0], tl_b[5:3]}), 32'({1'b0, 3'd6, 3'd7}));
    mv_b = 1'b1; step(); mv_b = 1'b0;
    check("b_sat", 32'({ap_b, tl_b[2:0], tl_b[5:3]}), 32'({1'b1, 3'd7, 3'd7}));
    sw_b = 1'b0;

    // three players: wrap, flag fall, newGame with switch high
    sw_c = 1'b1;
    repeat (3) step();
    check("c_running", 32'(run_c), 32'd1);
    mv_c = 1'b1;
    step(); check("c_ap1", 32'(ap_c), 32'd1);
    step(); check("c_ap2", 32'(ap_c), 32'd2);
    step(); check("c_ap0", 32'(ap_c), 32'd0);
    mv_c = 1'b0;
    for (int n = 0; n < 40 && !to_c; n++) step();
    check("c_timeout", 32'({to_c, run_c, lo_c}), 32'({1'b1, 1'b0, 2'd0}));
    check("c_timers", 32'(tl_c), 32'h330);
    ng_c = 1'b1; step(); ng_c = 1'b0;
    check("c_newgame", 32'({run_c, to_c, ap_c, tl_c}), 32'({1'b0, 1'b0, 2'd0, 12'h333}));
    step();
    check("c_rerun", 32'(run_c), 32'd1);
    sw_c = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
